// File: rtl/uart_reg_driver.sv
// uart_reg_driver: register-bus master that programs the UART core, loads 1..7 TX bytes, kicks TX and optionally drains RX.
// All bus outputs registered, one-cycle accesses; the TX stream is accepted at most one byte per two cycles.
module uart_reg_driver #(
  parameter logic [31:0] TIMEOUT_CYC = 32'd100000,
  parameter int          ADDR_W      = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [15:0]       baud_i,
  input  logic [2:0]        nbytes_i,
  input  logic              rx_drain_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [7:0]        out_data_o,
  output logic              out_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              reg_we,
  output logic              reg_re,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  input  logic [31:0]       reg_rdata,
  input  logic              intr_tx_i,
  input  logic              intr_rx_empty_i
);

  localparam logic [ADDR_W-1:0] A_BAUD   = ADDR_W'(32'h000);
  localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(32'h004);
  localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(32'h008);
  localparam logic [ADDR_W-1:0] A_RXEN   = ADDR_W'(32'h00C);
  localparam logic [ADDR_W-1:0] A_TXCLR  = ADDR_W'(32'h010);
  localparam logic [ADDR_W-1:0] A_LEVEL  = ADDR_W'(32'h018);
  localparam logic [ADDR_W-1:0] A_RDEN   = ADDR_W'(32'h01C);

  typedef enum logic [4:0] {
    S_IDLE, S_W_BAUD, S_W_CLR1, S_W_CLR0, S_W_RXEN, S_LOAD, S_W_TXD,
    S_W_LEVEL, S_W_GO, S_W_STOP, S_WAIT_TX, S_TO_STOP,
    S_RD_CHK, S_RD_REQ, S_RD_CAP, S_RD_WAIT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         baud_q, baud_d;
  logic [2:0]          nbytes_q, nbytes_d;
  logic                drain_q, drain_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [31:0]         to_cnt_q, to_cnt_d;
  logic [2:0]          rd_cnt_q, rd_cnt_d;
  logic                we_q, we_d, re_q, re_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                in_ready_q, in_ready_d, busy_q, busy_d;
  logic                done_q, done_d, error_q, error_d;
  logic [7:0]          out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    nbytes_d    = nbytes_q;
    drain_d     = drain_q;
    cnt_d       = cnt_q;
    to_cnt_d    = to_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    error_d     = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (nbytes_i == 3'd0) begin
            error_d = 1'b1;
          end else begin
            baud_d   = baud_i;
            nbytes_d = nbytes_i;
            drain_d  = rx_drain_i;
            cnt_d    = 3'd0;
            rd_cnt_d = 3'd0;
            state_d  = S_W_BAUD;
          end
        end
      end
      S_W_BAUD: state_d = S_W_CLR1;
      S_W_CLR1: state_d = S_W_CLR0;
      S_W_CLR0: state_d = S_W_RXEN;
      S_W_RXEN: state_d = S_LOAD;
      S_LOAD: begin
        if (in_valid_i && in_ready_q) begin
          cnt_d   = cnt_q + 3'd1;
          state_d = S_W_TXD;
        end
      end
      S_W_TXD:   state_d = (cnt_q == nbytes_q) ? S_W_LEVEL : S_LOAD;
      S_W_LEVEL: state_d = S_W_GO;
      S_W_GO:    state_d = S_W_STOP;
      S_W_STOP: begin
        to_cnt_d = 32'd0;
        state_d  = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (intr_tx_i) begin
          state_d = drain_q ? S_RD_CHK : S_DONE;
        end else if (to_cnt_q == TIMEOUT_CYC - 32'd1) begin
          error_d = 1'b1;
          state_d = S_TO_STOP;
        end else begin
          to_cnt_d = to_cnt_q + 32'd1;
        end
      end
      S_TO_STOP: state_d = S_IDLE;
      S_RD_CHK:  state_d = intr_rx_empty_i ? S_DONE : S_RD_REQ;
      S_RD_REQ:  state_d = S_RD_CAP;
      S_RD_CAP: begin
        out_data_d  = reg_rdata[7:0];
        out_valid_d = 1'b1;
        rd_cnt_d    = rd_cnt_q + 3'd1;
        // eighth read ends the drain even if the FIFO still reports data
        state_d     = (rd_cnt_q == 3'd7) ? S_DONE : S_RD_WAIT;
      end
      S_RD_WAIT: state_d = S_RD_CHK;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they are registered yet line up with the state.
  always_comb begin
    we_d    = 1'b0;
    re_d    = 1'b0;
    addr_d  = '0;
    wdata_d = 32'd0;
    case (state_d)
      S_W_BAUD:  begin we_d = 1'b1; addr_d = A_BAUD;   wdata_d = {16'd0, baud_d};    end
      S_W_CLR1:  begin we_d = 1'b1; addr_d = A_TXCLR;  wdata_d = 32'd1;              end
      S_W_CLR0:  begin we_d = 1'b1; addr_d = A_TXCLR;  wdata_d = 32'd0;              end
      S_W_RXEN:  begin we_d = 1'b1; addr_d = A_RXEN;   wdata_d = 32'd1;              end
      S_W_TXD:   begin we_d = 1'b1; addr_d = A_TXDATA; wdata_d = {24'd0, in_data_i}; end
      S_W_LEVEL: begin we_d = 1'b1; addr_d = A_LEVEL;  wdata_d = {29'd0, nbytes_q};  end
      S_W_GO:    begin we_d = 1'b1; addr_d = A_RDEN;   wdata_d = 32'd1;              end
      S_W_STOP,
      S_TO_STOP: begin we_d = 1'b1; addr_d = A_RDEN;   wdata_d = 32'd0;              end
      S_RD_REQ:  begin re_d = 1'b1; addr_d = A_RXDATA;                               end
      default: ;
    endcase
    in_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      baud_q      <= 16'd0;
      nbytes_q    <= 3'd0;
      drain_q     <= 1'b0;
      cnt_q       <= 3'd0;
      to_cnt_q    <= 32'd0;
      rd_cnt_q    <= 3'd0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      nbytes_q    <= nbytes_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
      to_cnt_q    <= to_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      we_q        <= we_d;
      re_q        <= re_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign reg_we      = we_q;
  assign reg_re      = re_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign in_ready_o  = in_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_uart_reg_driver.sv
// Directed bench for uart_reg_driver: write-trace model, stream feeder and a small RX FIFO model.
module tb_uart_reg_driver;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] baud;
    logic [2:0]  n;
    int          lat;
    int          nwr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, start_i, rx_drain_i, intr_tx_i;
  logic [15:0] baud_i;
  logic [2:0]  nbytes_i;
  logic        in_valid_i = 1'b0;
  logic [7:0]  in_data_i  = 8'd0;
  logic [31:0] reg_rdata  = 32'd0;
  logic        intr_rx_empty_i;

  logic        in_ready_o, out_valid_o, busy_o, done_o, error_o, reg_we, reg_re;
  logic [7:0]  out_data_o;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata;

  logic        t_in_ready_o, t_out_valid_o, t_busy_o, t_done_o, t_error_o, t_reg_we, t_reg_re;
  logic [7:0]  t_out_data_o;
  logic [11:0] t_reg_addr;
  logic [31:0] t_reg_wdata;

  uart_reg_driver #(.TIMEOUT_CYC(32'd100000), .ADDR_W(12)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .baud_i(baud_i), .nbytes_i(nbytes_i),
    .rx_drain_i(rx_drain_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .intr_tx_i(intr_tx_i), .intr_rx_empty_i(intr_rx_empty_i));

  uart_reg_driver #(.TIMEOUT_CYC(32'd20), .ADDR_W(12)) dut_to (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .baud_i(baud_i), .nbytes_i(nbytes_i),
    .rx_drain_i(rx_drain_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(t_in_ready_o),
    .out_data_o(t_out_data_o), .out_valid_o(t_out_valid_o), .busy_o(t_busy_o), .done_o(t_done_o),
    .error_o(t_error_o), .reg_we(t_reg_we), .reg_re(t_reg_re), .reg_addr(t_reg_addr), .reg_wdata(t_reg_wdata),
    .reg_rdata(reg_rdata), .intr_tx_i(intr_tx_i), .intr_rx_empty_i(intr_rx_empty_i));

  // TX byte source: pool[acc_n] is always the next byte to be accepted
  logic [7:0] pool [0:255];
  int         acc_n = 0;
  logic       feed_on = 1'b0, feed_rand = 1'b0;
  always @(posedge clk) begin
    if (in_valid_i && in_ready_o) acc_n <= acc_n + 1;
    #1;
    in_valid_i = feed_on && (!feed_rand || ($urandom_range(0, 1) == 1));
    in_data_i  = pool[acc_n];
  end

  // RX FIFO model: data returned the cycle after reg_re
  logic [7:0] rx_mem [0:31];
  int         rx_n = 0, rx_rd = 0;
  assign intr_rx_empty_i = (rx_rd >= rx_n);
  always @(posedge clk) begin
    if (reg_re) begin
      reg_rdata <= {24'd0, rx_mem[rx_rd]};
      rx_rd     <= rx_rd + 1;
    end
  end

  // Bus/strobe recorder for the main instance
  wr_t        wr_q[$];
  logic [7:0] out_q[$];
  int cyc = 0, rd_n = 0, bad_rd = 0, done_n = 0, err_n = 0, busy_n = 0;
  int done_cyc = 0, err_cyc = 0, last_out_cyc = 0;
  int v_both = 0, v_idle = 0, v_rdy = 0, v_done2 = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reg_we) wr_q.push_back('{reg_addr, reg_wdata});
    if (reg_re) begin
      rd_n <= rd_n + 1;
      if (reg_addr != 12'h008) bad_rd <= bad_rd + 1;
    end
    if (reg_we && reg_re) v_both <= v_both + 1;
    if (!reg_we && !reg_re && (reg_addr != 12'd0 || reg_wdata != 32'd0)) v_idle <= v_idle + 1;
    if (in_ready_o && reg_we) v_rdy <= v_rdy + 1;
    if (done_o && done_prev) v_done2 <= v_done2 + 1;
    done_prev <= done_o;
    if (done_o) begin done_n <= done_n + 1; done_cyc <= cyc + 1; end
    if (error_o) begin err_n <= err_n + 1; err_cyc <= cyc + 1; end
    if (busy_o) busy_n <= busy_n + 1;
    if (out_valid_o) begin out_q.push_back(out_data_o); last_out_cyc <= cyc + 1; end
  end

  int   checks = 0, failures = 0;
  wr_t  exp_q[$];
  wr_t  exp_basic [10];
  vec_t vt [4];
  int   st_cyc, wb, db, eb, rb, ob, ab, bb, cnt;
  int   stop_i, err_i, errs, tdone;
  logic [44:0] at_err;
  logic busy_after, found;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [15:0] b, input logic [2:0] n, input logic d);
    start_i = 1'b1; baud_i = b; nbytes_i = n; rx_drain_i = d;
    st_cyc = cyc;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int lim, input string name);
    int i;
    i = 0;
    do begin @(negedge clk); i++; end while (busy_o && i < lim);
    chk(name, 64'(busy_o), 64'd0);
    tick();
  endtask

  task automatic fill(input int n, input int seed);
    for (int i = 0; i < n; i++) pool[acc_n + i] = 8'(seed + i * 29);
  endtask

  task automatic build_exp(input logic [15:0] b, input int n);
    exp_q.delete();
    exp_q.push_back('{12'h000, {16'd0, b}});
    exp_q.push_back('{12'h010, 32'd1});
    exp_q.push_back('{12'h010, 32'd0});
    exp_q.push_back('{12'h00C, 32'd1});
    for (int i = 0; i < n; i++) exp_q.push_back('{12'h004, {24'd0, pool[acc_n + i]}});
    exp_q.push_back('{12'h018, 32'(n)});
    exp_q.push_back('{12'h01C, 32'd1});
    exp_q.push_back('{12'h01C, 32'd0});
  endtask

  task automatic check_trace(input string name, input int base);
    int bad;
    bad = 0;
    checks++;
    if (wr_q.size() - base != exp_q.size()) begin
      bad = 1;
      $display("FAIL %s write count got=%0d want=%0d", name, wr_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (wr_q[base + i] !== exp_q[i]) begin
          if (bad == 0)
            $display("FAIL %s write %0d got=(%0h,%0h) want=(%0h,%0h)", name, i,
                     wr_q[base + i].addr, wr_q[base + i].data, exp_q[i].addr, exp_q[i].data);
          bad++;
        end
      end
    end
    if (bad != 0) failures++;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; baud_i = 16'd0; nbytes_i = 3'd0; rx_drain_i = 1'b0; intr_tx_i = 1'b0;
    exp_basic = '{'{12'h000, 32'd10}, '{12'h010, 32'd1}, '{12'h010, 32'd0}, '{12'h00C, 32'd1},
                  '{12'h004, 32'hA5}, '{12'h004, 32'h3C}, '{12'h004, 32'hFF}, '{12'h018, 32'd3},
                  '{12'h01C, 32'd1}, '{12'h01C, 32'd0}};
    // {baud, nbytes, start-to-done cycles (4+2N+5), writes}
    vt[0] = '{16'h1234, 3'd1, 11, 8};
    vt[1] = '{16'hFFFF, 3'd7, 23, 14};
    vt[2] = '{16'd10,   3'd3, 15, 10};
    vt[3] = '{16'h0000, 3'd2, 13, 9};

    repeat (3) tick();
    @(negedge clk);
    chk("reset_outs", 64'({in_ready_o, out_valid_o, busy_o, done_o, error_o, reg_we, reg_re,
                           reg_addr, reg_wdata, out_data_o}), 64'd0);
    chk("reset_outs_to", 64'({t_in_ready_o, t_out_valid_o, t_busy_o, t_done_o, t_error_o, t_reg_we,
                              t_reg_re, t_reg_addr, t_reg_wdata, t_out_data_o}), 64'd0);
    tick();
    rst_i = 1'b0;
    tick();

    // Basic TX, intr_tx arrives 50 cycles after the kick write
    feed_on = 1'b1;
    pool[acc_n] = 8'hA5; pool[acc_n + 1] = 8'h3C; pool[acc_n + 2] = 8'hFF;
    exp_q.delete();
    foreach (exp_basic[i]) exp_q.push_back(exp_basic[i]);
    wb = wr_q.size(); db = done_n; rb = rd_n; eb = err_n;
    issue(16'd10, 3'd3, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (reg_we && reg_addr == 12'h01C && reg_wdata == 32'd1) found = 1'b1;
    end
    chk("basic_go_write", 64'(found), 64'd1);
    repeat (50) tick();
    intr_tx_i = 1'b1;
    wait_idle(100, "basic_idle");
    intr_tx_i = 1'b0;
    check_trace("basic_trace", wb);
    chk("basic_done", 64'(done_n - db), 64'd1);
    chk("basic_no_read", 64'(rd_n - rb), 64'd0);
    chk("basic_no_err", 64'(err_n - eb), 64'd0);

    // Table: intr_tx already high, check trace and start-to-done latency
    intr_tx_i = 1'b1;
    for (int v = 0; v < 4; v++) begin
      fill(int'(vt[v].n), v * 64 + 3);
      build_exp(vt[v].baud, int'(vt[v].n));
      wb = wr_q.size(); db = done_n; eb = err_n;
      issue(vt[v].baud, vt[v].n, 1'b0);
      wait_idle(200, $sformatf("vec%0d_idle", v));
      check_trace($sformatf("vec%0d_trace", v), wb);
      chk($sformatf("vec%0d_nwr", v), 64'(wr_q.size() - wb), 64'(vt[v].nwr));
      chk($sformatf("vec%0d_latency", v), 64'(done_cyc - st_cyc), 64'(vt[v].lat + 1));
      chk($sformatf("vec%0d_done", v), 64'(done_n - db), 64'd1);
      chk($sformatf("vec%0d_no_err", v), 64'(err_n - eb), 64'd0);
    end

    // Stream backpressure with random valid
    feed_rand = 1'b1;
    fill(7, 200);
    build_exp(16'h0003, 7);
    wb = wr_q.size(); ab = acc_n;
    issue(16'h0003, 3'd7, 1'b0);
    wait_idle(400, "bp_idle");
    feed_rand = 1'b0;
    check_trace("bp_trace", wb);
    chk("bp_accepted", 64'(acc_n - ab), 64'd7);

    // Bad command: nbytes=0
    wb = wr_q.size(); eb = err_n; rb = rd_n; bb = busy_n;
    issue(16'h00AA, 3'd0, 1'b0);
    repeat (4) tick();
    chk("bad_err_count", 64'(err_n - eb), 64'd1);
    chk("bad_err_cycle", 64'(err_cyc - st_cyc), 64'd2);
    chk("bad_no_bus", 64'((wr_q.size() - wb) + (rd_n - rb)), 64'd0);
    chk("bad_not_busy", 64'(busy_n - bb), 64'd0);

    // Starts while busy are ignored
    fill(3, 90);
    build_exp(16'h0101, 3);
    wb = wr_q.size(); db = done_n; rb = rd_n;
    issue(16'h0101, 3'd3, 1'b0);
    repeat (3) tick();
    issue(16'h5555, 3'd5, 1'b1);
    repeat (3) tick();
    issue(16'h6666, 3'd6, 1'b1);
    wait_idle(200, "busy_idle");
    repeat (5) tick();
    check_trace("busy_trace", wb);
    chk("busy_done", 64'(done_n - db), 64'd1);
    chk("busy_no_read", 64'(rd_n - rb), 64'd0);

    // RX drain of two bytes
    rx_mem[rx_n] = 8'h11; rx_mem[rx_n + 1] = 8'h22;
    rx_n = rx_n + 2;
    fill(1, 7);
    build_exp(16'h0020, 1);
    wb = wr_q.size(); db = done_n; rb = rd_n; ob = out_q.size();
    issue(16'h0020, 3'd1, 1'b1);
    wait_idle(200, "drain_idle");
    check_trace("drain_trace", wb);
    chk("drain_reads", 64'(rd_n - rb), 64'd2);
    chk("drain_nout", 64'(out_q.size() - ob), 64'd2);
    if (out_q.size() - ob == 2) begin
      chk("drain_byte0", 64'(out_q[ob]), 64'h11);
      chk("drain_byte1", 64'(out_q[ob + 1]), 64'h22);
    end
    chk("drain_done", 64'(done_n - db), 64'd1);
    chk("drain_done_after_out", 64'(done_cyc > last_out_cyc), 64'd1);

    // Drain bounded to eight reads with nine bytes queued
    for (int i = 0; i < 9; i++) rx_mem[rx_n + i] = 8'(8'h40 + i);
    rx_n = rx_n + 9;
    fill(1, 55);
    rb = rd_n; ob = out_q.size(); db = done_n;
    issue(16'h0021, 3'd1, 1'b1);
    wait_idle(300, "bound_idle");
    chk("bound_reads", 64'(rd_n - rb), 64'd8);
    chk("bound_nout", 64'(out_q.size() - ob), 64'd8);
    if (out_q.size() - ob == 8) chk("bound_last_byte", 64'(out_q[ob + 7]), 64'h47);
    chk("bound_done", 64'(done_n - db), 64'd1);

    // Timeout on the TIMEOUT_CYC=20 instance
    intr_tx_i = 1'b0;
    fill(2, 17);
    stop_i = -1; err_i = -1; errs = 0; tdone = 0; at_err = '0; busy_after = 1'b1;
    issue(16'h0009, 3'd2, 1'b0);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (t_reg_we && t_reg_addr == 12'h01C && t_reg_wdata == 32'd0 && stop_i < 0) stop_i = i;
      if (err_i >= 0 && i == err_i + 1) busy_after = t_busy_o;
      if (t_done_o) tdone++;
      if (t_error_o) begin errs++; err_i = i; at_err = {t_reg_we, t_reg_addr, t_reg_wdata}; end
    end
    tick();
    chk("to_err_count", 64'(errs), 64'd1);
    chk("to_err_delay", 64'(err_i - stop_i), 64'd21);
    chk("to_stop_write", 64'(at_err), 64'({1'b1, 12'h01C, 32'd0}));
    chk("to_no_done", 64'(tdone), 64'd0);
    chk("to_busy_falls", 64'(busy_after), 64'd0);
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Reset in LOAD after two bytes, then a full replay
    intr_tx_i = 1'b1;
    fill(5, 120);
    cnt = 0;
    issue(16'h0033, 3'd5, 1'b0);
    for (int i = 0; i < 100 && cnt < 2; i++) begin
      @(negedge clk);
      if (reg_we && reg_addr == 12'h004) cnt++;
    end
    chk("rst_two_bytes", 64'(cnt), 64'd2);
    tick();
    rst_i = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_outs", 64'({in_ready_o, out_valid_o, busy_o, done_o, error_o, reg_we, reg_re,
                         reg_addr, reg_wdata, out_data_o}), 64'd0);
    rst_i = 1'b0;
    tick();
    fill(2, 33);
    build_exp(16'h0044, 2);
    wb = wr_q.size(); db = done_n;
    issue(16'h0044, 3'd2, 1'b0);
    wait_idle(200, "replay_idle");
    check_trace("replay_trace", wb);
    chk("replay_done", 64'(done_n - db), 64'd1);

    // Bus rules over the whole run
    chk("rule_we_re_excl", 64'(v_both), 64'd0);
    chk("rule_idle_bus_zero", 64'(v_idle), 64'd0);
    chk("rule_ready_in_write", 64'(v_rdy), 64'd0);
    chk("rule_read_addr", 64'(bad_rd), 64'd0);
    chk("rule_done_one_cycle", 64'(v_done2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
